// File: rtl/cpu_seq.sv
// Instruction sequencer: steps each instruction through FETCH, DECODE and one
// execute state, issuing the memory, PC and register-enable strobes per step.
//
// state   | meaning
// IDLE    | stopped, waits for RUN
// FETCH   | read opcode at PC, load IR and bump PC on MEM_RDY
// DECODE  | one cycle for the decoder strobes to settle
// OPERAND | read immediate at PC (JMP target or LDD data)
// MEMOP   | read/write through pointer SMH:SML (LD/STR)
// EXEC    | single-cycle ALU / pointer / flag update
module cpu_seq (
  input  logic       CLK1,
  input  logic       RST_C,
  input  logic       RUN,
  input  logic       MEM_RDY,
  input  logic       JMP,
  input  logic       LDD,
  input  logic       LD,
  input  logic       STR,
  input  logic       ARI,
  input  logic       LOG,
  input  logic       SEI,
  input  logic       SMH,
  input  logic       SML,
  input  logic       W_CAR,
  output logic       IR_LD,
  output logic       PC_INC,
  output logic       PC_LD,
  output logic       ADDR_SEL,
  output logic       MEM_RD,
  output logic       MEM_WR,
  output logic       ACC_WE,
  output logic       CAR_WE,
  output logic       PTRH_WE,
  output logic       PTRL_WE,
  output logic       IE_SET,
  output logic       BUSY,
  output logic [7:0] INSTR_CNT
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FETCH   = 3'd1;
  localparam logic [2:0] S_DECODE  = 3'd2;
  localparam logic [2:0] S_OPERAND = 3'd3;
  localparam logic [2:0] S_MEMOP   = 3'd4;
  localparam logic [2:0] S_EXEC    = 3'd5;

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       busy_q;
  logic       retire;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    retire   = 1'b0;
    IR_LD    = 1'b0;
    PC_INC   = 1'b0;
    PC_LD    = 1'b0;
    ADDR_SEL = 1'b0;
    MEM_RD   = 1'b0;
    MEM_WR   = 1'b0;
    ACC_WE   = 1'b0;
    CAR_WE   = 1'b0;
    PTRH_WE  = 1'b0;
    PTRL_WE  = 1'b0;
    IE_SET   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (RUN) state_d = S_FETCH;
      end
      S_FETCH: begin
        MEM_RD = 1'b1;
        if (MEM_RDY) begin
          IR_LD   = 1'b1;
          PC_INC  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (JMP || LDD)     state_d = S_OPERAND;
        else if (LD || STR) state_d = S_MEMOP;
        else                state_d = S_EXEC;
      end
      S_OPERAND: begin
        MEM_RD = 1'b1;
        if (MEM_RDY) begin
          // JMP wins over LDD so PC_LD and PC_INC can never coincide
          if (JMP) begin
            PC_LD = 1'b1;
          end else if (LDD) begin
            ACC_WE = 1'b1;
            PC_INC = 1'b1;
          end
          retire = 1'b1;
        end
      end
      S_MEMOP: begin
        ADDR_SEL = 1'b1;
        if (LD) begin
          MEM_RD = 1'b1;
          ACC_WE = MEM_RDY;
        end else if (STR) begin
          MEM_WR = 1'b1;
        end
        retire = MEM_RDY;
      end
      S_EXEC: begin
        ACC_WE  = ARI | LOG;
        CAR_WE  = W_CAR;
        PTRH_WE = SMH;
        PTRL_WE = SML;
        IE_SET  = SEI;
        retire  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (retire) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = RUN ? S_FETCH : S_IDLE;
    end
  end

  always_ff @(posedge CLK1 or posedge RST_C) begin
    if (RST_C) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign BUSY      = busy_q;
  assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_cpu_seq.sv
// Bench for cpu_seq: directed instruction sequences with literal expectations,
// then random traffic checked every cycle against an instruction-progress model.
module tb_cpu_seq;

  logic       CLK1 = 1'b0;
  logic       RST_C, RUN, MEM_RDY;
  logic       JMP, LDD, LD, STR, ARI, LOG, SEI, SMH, SML, W_CAR;
  logic       IR_LD, PC_INC, PC_LD, ADDR_SEL, MEM_RD, MEM_WR;
  logic       ACC_WE, CAR_WE, PTRH_WE, PTRL_WE, IE_SET, BUSY;
  logic [7:0] INSTR_CNT;
  logic [10:0] strb;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  localparam logic [9:0] D_JMP  = 10'b1000000000;
  localparam logic [9:0] D_LDD  = 10'b0100000000;
  localparam logic [9:0] D_LD   = 10'b0010000000;
  localparam logic [9:0] D_STR  = 10'b0001000000;
  localparam logic [9:0] D_ARI  = 10'b0000100000;
  localparam logic [9:0] D_LOG  = 10'b0000010000;
  localparam logic [9:0] D_SEI  = 10'b0000001000;
  localparam logic [9:0] D_SMH  = 10'b0000000100;
  localparam logic [9:0] D_SML  = 10'b0000000010;
  localparam logic [9:0] D_WCAR = 10'b0000000001;

  // strobe vector bit order: IR_LD PC_INC PC_LD ADDR_SEL MEM_RD MEM_WR ACC_WE CAR_WE PTRH PTRL IE
  localparam logic [10:0] P_NONE    = 11'b00000000000;
  localparam logic [10:0] P_FETCH   = 11'b11001000000;
  localparam logic [10:0] P_ALU_CAR = 11'b00000011000;
  localparam logic [10:0] P_LOG_PTR = 11'b00000010111;
  localparam logic [10:0] P_RD_WAIT = 11'b00001000000;
  localparam logic [10:0] P_JMP_LD  = 11'b00101000000;
  localparam logic [10:0] P_STR     = 11'b00010100000;
  localparam logic [10:0] P_LD      = 11'b00011010000;
  localparam logic [10:0] P_LDD     = 11'b01001010000;

  cpu_seq dut (
    .CLK1(CLK1), .RST_C(RST_C), .RUN(RUN), .MEM_RDY(MEM_RDY),
    .JMP(JMP), .LDD(LDD), .LD(LD), .STR(STR), .ARI(ARI), .LOG(LOG),
    .SEI(SEI), .SMH(SMH), .SML(SML), .W_CAR(W_CAR),
    .IR_LD(IR_LD), .PC_INC(PC_INC), .PC_LD(PC_LD), .ADDR_SEL(ADDR_SEL),
    .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .ACC_WE(ACC_WE), .CAR_WE(CAR_WE),
    .PTRH_WE(PTRH_WE), .PTRL_WE(PTRL_WE), .IE_SET(IE_SET), .BUSY(BUSY),
    .INSTR_CNT(INSTR_CNT)
  );

  always #5 CLK1 = ~CLK1;

  assign strb = {IR_LD, PC_INC, PC_LD, ADDR_SEL, MEM_RD, MEM_WR,
                 ACC_WE, CAR_WE, PTRH_WE, PTRL_WE, IE_SET};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h expected=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input logic run, input logic rdy, input logic [9:0] dec);
    RUN = run;
    MEM_RDY = rdy;
    {JMP, LDD, LD, STR, ARI, LOG, SEI, SMH, SML, W_CAR} = dec;
  endtask

  task automatic cyc(input logic run, input logic rdy, input logic [9:0] dec);
    apply(run, rdy, dec);
    @(posedge CLK1); #1;
  endtask

  task automatic cycc(input logic run, input logic rdy, input logic [9:0] dec,
                      input logic [10:0] exp, input string nm);
    apply(run, rdy, dec);
    #2;
    chk(nm, {21'd0, strb}, {21'd0, exp});
    @(posedge CLK1); #1;
  endtask

  // Model: progress through the current instruction rather than a state code.
  localparam int K_ALU = 0;
  localparam int K_OP  = 1;
  localparam int K_MEM = 2;
  bit m_busy = 1'b0, m_fetched = 1'b0, m_decoded = 1'b0;
  int m_kind = K_ALU;
  int m_cnt = 0;

  always @(negedge CLK1) begin
    logic [10:0] e;
    logic        eb;
    logic [7:0]  ec;
    if (chk_en) begin
      e  = '0;
      eb = m_busy;
      ec = m_cnt[7:0];
      if (RST_C) begin
        eb = 1'b0;
        ec = 8'd0;
      end else if (m_busy) begin
        if (!m_fetched) begin
          e[10] = MEM_RDY; e[9] = MEM_RDY; e[6] = 1'b1;
        end else if (m_decoded) begin
          case (m_kind)
            K_OP: begin
              e[6] = 1'b1;
              e[8] = MEM_RDY & JMP;
              e[9] = MEM_RDY & ~JMP & LDD;
              e[4] = MEM_RDY & ~JMP & LDD;
            end
            K_MEM: begin
              e[7] = 1'b1;
              e[6] = LD;
              e[4] = LD & MEM_RDY;
              e[5] = ~LD & STR;
            end
            default: begin
              e[4] = ARI | LOG; e[3] = W_CAR; e[2] = SMH; e[1] = SML; e[0] = SEI;
            end
          endcase
        end
      end
      chk("strobes", {21'd0, strb}, {21'd0, e});
      chk("busy", {31'd0, BUSY}, {31'd0, eb});
      chk("instr_cnt", {24'd0, INSTR_CNT}, {24'd0, ec});
      chk("rd_wr_excl", {31'd0, MEM_RD & MEM_WR}, 32'd0);
      chk("inc_ld_excl", {31'd0, PC_INC & PC_LD}, 32'd0);

      if (RST_C) begin
        m_busy = 1'b0; m_fetched = 1'b0; m_decoded = 1'b0; m_cnt = 0;
      end else if (!m_busy) begin
        m_busy = RUN;
      end else if (!m_fetched) begin
        m_fetched = MEM_RDY;
      end else if (!m_decoded) begin
        m_decoded = 1'b1;
        if (JMP || LDD)     m_kind = K_OP;
        else if (LD || STR) m_kind = K_MEM;
        else                m_kind = K_ALU;
      end else if (m_kind == K_ALU || MEM_RDY) begin
        m_cnt     = (m_cnt + 1) % 256;
        m_fetched = 1'b0;
        m_decoded = 1'b0;
        m_busy    = RUN;
      end
    end
  end

  initial begin
    logic [9:0] dec;
    RST_C = 1'b1;
    apply(1'b0, 1'b0, 10'd0);
    #1 chk_en = 1'b1;
    repeat (2) @(posedge CLK1);
    #3;
    chk("rst_strobes", {21'd0, strb}, {21'd0, P_NONE});
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    chk("rst_cnt", {24'd0, INSTR_CNT}, 32'd0);
    @(posedge CLK1); #1;

    // three ALU+carry instructions back to back
    RST_C = 1'b0;
    cycc(1'b1, 1'b1, D_ARI | D_WCAR, P_NONE, "idle_release");
    for (int k = 0; k < 9; k++) begin
      if (k % 3 == 0)      cycc(1'b1, 1'b1, D_ARI | D_WCAR, P_FETCH, "alu_fetch");
      else if (k % 3 == 1) cycc(1'b1, 1'b1, D_ARI | D_WCAR, P_NONE, "alu_decode");
      else                 cycc(1'b1, 1'b1, D_ARI | D_WCAR, P_ALU_CAR, "alu_exec");
    end
    chk("cnt_after_9", {24'd0, INSTR_CNT}, 32'd3);

    // JMP with two wait states in OPERAND
    cycc(1'b1, 1'b1, D_JMP, P_FETCH, "jmp_fetch");
    cycc(1'b1, 1'b1, D_JMP, P_NONE, "jmp_decode");
    cycc(1'b1, 1'b0, D_JMP, P_RD_WAIT, "jmp_wait1");
    cycc(1'b1, 1'b0, D_JMP, P_RD_WAIT, "jmp_wait2");
    cycc(1'b1, 1'b1, D_JMP, P_JMP_LD, "jmp_load");
    chk("cnt_after_jmp", {24'd0, INSTR_CNT}, 32'd4);

    // STR then LD through the pointer
    cycc(1'b1, 1'b1, D_STR, P_FETCH, "str_fetch");
    cycc(1'b1, 1'b1, D_STR, P_NONE, "str_decode");
    cycc(1'b1, 1'b1, D_STR, P_STR, "str_memop");
    cycc(1'b1, 1'b1, D_LD, P_FETCH, "ld_fetch");
    cycc(1'b1, 1'b1, D_LD, P_NONE, "ld_decode");
    cycc(1'b1, 1'b1, D_LD, P_LD, "ld_memop");

    // logic op with pointer and interrupt-enable writes
    cycc(1'b1, 1'b1, D_LOG | D_SEI | D_SMH | D_SML, P_FETCH, "log_fetch");
    cycc(1'b1, 1'b1, D_LOG | D_SEI | D_SMH | D_SML, P_NONE, "log_decode");
    cycc(1'b1, 1'b1, D_LOG | D_SEI | D_SMH | D_SML, P_LOG_PTR, "log_exec");
    chk("cnt_after_log", {24'd0, INSTR_CNT}, 32'd7);

    // RUN drops during DECODE of an LDD
    cycc(1'b1, 1'b1, D_LDD, P_FETCH, "ldd_fetch");
    cycc(1'b0, 1'b1, D_LDD, P_NONE, "ldd_decode");
    cycc(1'b0, 1'b1, D_LDD, P_LDD, "ldd_operand");
    chk("ldd_busy", {31'd0, BUSY}, 32'd0);
    chk("ldd_cnt", {24'd0, INSTR_CNT}, 32'd8);
    cycc(1'b0, 1'b1, D_LDD, P_NONE, "ldd_idle");

    // 255 retires, then reset in the middle of a stalled LD
    RST_C = 1'b1;
    cyc(1'b0, 1'b1, 10'd0);
    RST_C = 1'b0;
    cyc(1'b1, 1'b1, D_ARI);
    repeat (255) begin
      cyc(1'b1, 1'b1, D_ARI); cyc(1'b1, 1'b1, D_ARI); cyc(1'b1, 1'b1, D_ARI);
    end
    chk("cnt_255", {24'd0, INSTR_CNT}, 32'hFF);
    cyc(1'b1, 1'b1, D_LD);
    cyc(1'b1, 1'b1, D_LD);
    apply(1'b1, 1'b0, D_LD);
    #2 RST_C = 1'b1;
    #1;
    chk("midrst_strobes", {21'd0, strb}, {21'd0, P_NONE});
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_cnt", {24'd0, INSTR_CNT}, 32'd0);
    @(posedge CLK1); #1;
    RST_C = 1'b0;

    // separate run of 256 retires wraps to zero
    cyc(1'b1, 1'b1, D_LOG);
    repeat (255) begin
      cyc(1'b1, 1'b1, D_LOG); cyc(1'b1, 1'b1, D_LOG); cyc(1'b1, 1'b1, D_LOG);
    end
    chk("wrap_pre", {24'd0, INSTR_CNT}, 32'hFF);
    repeat (3) cyc(1'b1, 1'b1, D_LOG);
    chk("wrap_cnt", {24'd0, INSTR_CNT}, 32'h00);

    // random traffic, model-checked every cycle
    for (int i = 0; i < 3000; i++) begin
      RST_C = ($urandom_range(0, 199) == 0);
      for (int b = 0; b < 10; b++) dec[b] = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 7, dec);
    end
    RST_C = 1'b0;
    repeat (4) cyc(1'b0, 1'b1, 10'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
